// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// alu_share_arbiter : round-robin share of one Y86 OPq ALU between two
//                     requesters, with a registered one-entry response slot.
// Optional macro ALU_STATS_EN adds saturating grant/overflow counters.
// Revision 1.0
// ============================================================================
module alu_share_arbiter #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_op0,
  input  logic [1:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_out,
  output logic             resp_of,
  output logic             resp_zf,
  output logic             resp_sf
`ifdef ALU_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_grant0,
  output logic [CNT_W-1:0] stat_grant1,
  output logic [CNT_W-1:0] stat_ovf
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             of_q, of_d;
  logic             zf_q, zf_d;
  logic             sf_q, sf_d;

  logic             can_accept;
  logic             gnt;
  logic             accept;
  logic [1:0]       op;
  logic             is_sub;
  logic [WIDTH-1:0] a, b, b_eff, sum, res;
  logic             alu_of;

  always_comb begin : arb
    can_accept = (state_q == EMPTY) || resp_ready;
    gnt        = (req_valid == 2'b11) ? rr_ptr_q : req_valid[1];
    req_ready  = 2'b00;
    if (rst_n && can_accept && (req_valid != 2'b00)) begin
      req_ready[gnt] = 1'b1;
    end
    accept = |(req_valid & req_ready);
  end

  // Subtraction reuses the adder as a + ~b + 1, so overflow uses the inverted b sign.
  always_comb begin : alu
    op     = gnt ? req_op1 : req_op0;
    a      = gnt ? req_a1 : req_a0;
    b      = gnt ? req_b1 : req_b0;
    is_sub = (op == 2'b01);
    b_eff  = is_sub ? ~b : b;
    sum    = a + b_eff + {{(WIDTH-1){1'b0}}, is_sub};
    res    = sum;
    alu_of = 1'b0;
    case (op)
      2'b00, 2'b01: alu_of = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      2'b10:        res    = a & b;
      default:      res    = a ^ b;
    endcase
  end

  always_comb begin : nxt
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    out_d    = out_q;
    of_d     = of_q;
    zf_d     = zf_q;
    sf_d     = sf_q;
    if (accept) begin
      state_d  = FULL;
      rr_ptr_d = ~gnt;
      id_d     = gnt;
      out_d    = res;
      of_d     = alu_of;
      zf_d     = (res == '0);
      sf_d     = res[WIDTH-1];
    end else if (resp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      rr_ptr_q <= 1'b0;
      id_q     <= 1'b0;
      out_q    <= '0;
      of_q     <= 1'b0;
      zf_q     <= 1'b0;
      sf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      out_q    <= out_d;
      of_q     <= of_d;
      zf_q     <= zf_d;
      sf_q     <= sf_d;
    end
  end

  assign resp_valid = (state_q == FULL);
  assign resp_id    = id_q;
  assign resp_out   = out_q;
  assign resp_of    = of_q;
  assign resp_zf    = zf_q;
  assign resp_sf    = sf_q;

`ifdef ALU_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] grant0_q, grant0_d;
  logic [CNT_W-1:0] grant1_q, grant1_d;
  logic [CNT_W-1:0] ovf_q, ovf_d;

  always_comb begin : stats_nxt
    grant0_d = grant0_q;
    grant1_d = grant1_q;
    ovf_d    = ovf_q;
    if (accept && !gnt && (grant0_q != CNT_MAX)) grant0_d = grant0_q + CNT_ONE;
    if (accept && gnt && (grant1_q != CNT_MAX))  grant1_d = grant1_q + CNT_ONE;
    if (accept && alu_of && (ovf_q != CNT_MAX))  ovf_d    = ovf_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant0_q <= '0;
      grant1_q <= '0;
      ovf_q    <= '0;
    end else begin
      grant0_q <= grant0_d;
      grant1_q <= grant1_d;
      ovf_q    <= ovf_d;
    end
  end

  assign stat_grant0 = grant0_q;
  assign stat_grant1 = grant1_q;
  assign stat_ovf    = ovf_q;
`else
  // CNT_W only sizes the statistics counters, absent in this build.
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for alu_share_arbiter: directed scenarios plus random traffic, all
// responses scored against a queue filled from a signed-arithmetic model.
module tb_alu_share_arbiter;
  localparam int WIDTH = 64;
  localparam int CNT_W = 32;

  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] out;
    logic             of;
    logic             zf;
    logic             sf;
  } rsp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req_valid = 2'b00;
  logic [1:0]       req_ready;
  logic [1:0]       req_op0 = 2'b00, req_op1 = 2'b00;
  logic [WIDTH-1:0] req_a0 = '0, req_a1 = '0, req_b0 = '0, req_b1 = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b1;
  logic             resp_id;
  logic [WIDTH-1:0] resp_out;
  logic             resp_of, resp_zf, resp_sf;
`ifdef ALU_STATS_EN
  logic [CNT_W-1:0] stat_grant0, stat_grant1, stat_ovf;
`endif

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op0    (req_op0),
    .req_op1    (req_op1),
    .req_a0     (req_a0),
    .req_a1     (req_a1),
    .req_b0     (req_b0),
    .req_b1     (req_b1),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_out   (resp_out),
    .resp_of    (resp_of),
    .resp_zf    (resp_zf),
    .resp_sf    (resp_sf)
`ifdef ALU_STATS_EN
    ,
    .stat_grant0(stat_grant0),
    .stat_grant1(stat_grant1),
    .stat_ovf   (stat_ovf)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_acc    = 0;

  req_t sq0[$];
  req_t sq1[$];
  rsp_t sb[$];
  req_t cur0, cur1;
  logic [1:0] acc_last = 2'b00;

  // Reference state: slot occupancy, round-robin pointer, counters.
  logic m_full = 1'b0;
  logic m_rr   = 1'b0;
  longint unsigned m_g0 = 0, m_g1 = 0, m_ov = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic req_t mk(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_t r;
    r.op = op;
    r.a  = a;
    r.b  = b;
    return r;
  endfunction

  // Signed results are computed one bit wider; overflow = result does not fit WIDTH bits.
  function automatic rsp_t model(input logic id, input req_t r);
    logic signed [WIDTH:0] wide;
    logic signed [WIDTH:0] sa, sb_;
    rsp_t x;
    sa  = $signed({r.a[WIDTH-1], r.a});
    sb_ = $signed({r.b[WIDTH-1], r.b});
    case (r.op)
      2'd0:    wide = sa + sb_;
      2'd1:    wide = sa - sb_;
      2'd2:    wide = {1'b0, r.a & r.b};
      default: wide = {1'b0, r.a ^ r.b};
    endcase
    x.id  = id;
    x.out = wide[WIDTH-1:0];
    x.of  = (r.op <= 2'd1) && (wide[WIDTH] != wide[WIDTH-1]);
    x.zf  = (x.out == '0);
    x.sf  = x.out[WIDTH-1];
    return x;
  endfunction

  function automatic logic [WIDTH-1:0] rval();
    case ($urandom_range(0, 5))
      0:       return 64'h7FFF_FFFF_FFFF_FFFF;
      1:       return 64'h8000_0000_0000_0000;
      2:       return '0;
      3:       return '1;
      4:       return 64'($urandom_range(0, 15));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Driver: present the head of each requester's queue, hold it until accepted.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (acc_last[0]) void'(sq0.pop_front());
      if (acc_last[1]) void'(sq1.pop_front());
      req_valid[0] = (sq0.size() != 0);
      req_valid[1] = (sq1.size() != 0);
      if (sq0.size() != 0) cur0 = sq0[0];
      if (sq1.size() != 0) cur1 = sq1[0];
      req_op0 = cur0.op; req_a0 = cur0.a; req_b0 = cur0.b;
      req_op1 = cur1.op; req_a1 = cur1.a; req_b1 = cur1.b;
    end
  end

  // Grant/handshake checker and scoreboard producer.
  always @(negedge clk) begin
    logic [1:0] exp_ready;
    logic       g;
    rsp_t       e;
    if (!rst_n) begin
      check("ready_in_reset", {62'd0, req_ready}, 64'd0);
      m_full   = 1'b0;
      m_rr     = 1'b0;
      m_g0     = 0; m_g1 = 0; m_ov = 0;
      acc_last = 2'b00;
      sb.delete();
    end else begin
      check("resp_valid", {63'd0, resp_valid}, {63'd0, m_full});
`ifdef ALU_STATS_EN
      check("stat_grant0", {32'd0, stat_grant0}, m_g0);
      check("stat_grant1", {32'd0, stat_grant1}, m_g1);
      check("stat_ovf", {32'd0, stat_ovf}, m_ov);
`endif
      exp_ready = 2'b00;
      g = (req_valid == 2'b11) ? m_rr : req_valid[1];
      if ((req_valid != 2'b00) && (!m_full || resp_ready)) exp_ready[g] = 1'b1;
      check("req_ready", {62'd0, req_ready}, {62'd0, exp_ready});
      acc_last = exp_ready;
      if (exp_ready != 2'b00) begin
        e = model(g, g ? cur1 : cur0);
        sb.push_back(e);
        m_rr   = ~g;
        m_full = 1'b1;
        n_acc++;
        if (!g) m_g0++; else m_g1++;
        if (e.of) m_ov++;
      end else if (m_full && resp_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // Monitor: compare whatever the slot presents against the oldest expectation.
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n && resp_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL resp_unexpected: got id=%0d out=%h expected no response", resp_id, resp_out);
      end else begin
        e = sb[0];
        check("resp_out", resp_out, e.out);
        check("resp_id_of_zf_sf", {60'd0, resp_id, resp_of, resp_zf, resp_sf},
              {60'd0, e.id, e.of, e.zf, e.sf});
        if (resp_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (sq0.size() == 0 && sq1.size() == 0 && sb.size() == 0 && !m_full) return;
    end
    n_checks++;
    $display("FAIL idle_timeout: got busy after 200 cycles expected idle");
  endtask

  task automatic wait_accepts(input int target);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (n_acc >= target) return;
    end
    n_checks++;
    $display("FAIL accept_timeout: got %0d accepts expected %0d", n_acc, target);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    int target;
    // Reset with both requesters pending; first grant after release goes to 0.
    sq0.push_back(mk(2'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD));
    sq1.push_back(mk(2'd1, 64'd1, 64'd2));
    sq0.push_back(mk(2'd3, 64'h5A, 64'h5A));
    sq1.push_back(mk(2'd1, 64'd7, 64'd4));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_resp_out", resp_out, 64'd0);
    check("reset_resp_flags", {60'd0, resp_id, resp_of, resp_zf, resp_sf}, 64'd0);
    wait_idle();

    // Backpressure: hold a full slot for 3 cycles, then pop and push from requester 1.
    target = n_acc + 1;
    sq0.push_back(mk(2'd0, 64'd5, 64'd6));
    wait_accepts(target);
    #1 resp_ready = 1'b0;
    sq1.push_back(mk(2'd2, 64'hF0F0, 64'h0FF0));
    repeat (3) @(posedge clk);
    #1 resp_ready = 1'b1;
    wait_idle();

    // Three accepts from a fresh reset, then reset while the slot is full.
    do_reset();
    target = n_acc + 3;
    sq0.push_back(mk(2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1));
    sq1.push_back(mk(2'd2, 64'hFFFF, 64'h00FF));
    sq0.push_back(mk(2'd3, 64'h1234, 64'h4321));
    wait_accepts(target);
    #1 resp_ready = 1'b0;
    @(negedge clk);
`ifdef ALU_STATS_EN
    check("pre_reset_grant0", {32'd0, stat_grant0}, 64'd2);
    check("pre_reset_grant1", {32'd0, stat_grant1}, 64'd1);
    check("pre_reset_ovf", {32'd0, stat_ovf}, 64'd1);
`endif
    do_reset();
    @(negedge clk);
    check("midreset_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("midreset_resp_out", resp_out, 64'd0);
`ifdef ALU_STATS_EN
    check("midreset_stats", {32'd0, stat_grant0 | stat_grant1 | stat_ovf}, 64'd0);
`endif
    #1 resp_ready = 1'b1;
    sq1.push_back(mk(2'd0, 64'd3, 64'd4));
    sq0.push_back(mk(2'd1, 64'd3, 64'd3));
    wait_idle();

    // Random traffic with random consumer backpressure.
    for (int c = 0; c < 400; c++) begin
      logic [WIDTH-1:0] ra, rb;
      @(posedge clk);
      #2;
      resp_ready = ($urandom_range(0, 3) != 0);
      if (sq0.size() < 2 && $urandom_range(0, 1) == 1) begin
        ra = rval();
        rb = ($urandom_range(0, 3) == 0) ? ra : rval();
        sq0.push_back(mk(2'($urandom_range(0, 3)), ra, rb));
      end
      if (sq1.size() < 2 && $urandom_range(0, 1) == 1) begin
        ra = rval();
        rb = ($urandom_range(0, 3) == 0) ? ra : rval();
        sq1.push_back(mk(2'($urandom_range(0, 3)), ra, rb));
      end
    end
    #1 resp_ready = 1'b1;
    wait_idle();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
